// File: rtl/physics_sequencer.sv
// rtl/physics_sequencer.sv - frame-level scheduler for the physics calc sweep, collision pass and commit
module physics_sequencer #(
    parameter int SPRITES       = 9,
    parameter int SETTLE_CYCLES = 65536,
    parameter int FRAME_CYCLES  = 2_700_000,
    localparam int IW = (SPRITES > 1) ? $clog2(SPRITES) : 1
) (
    input  logic          clk_162,
    input  logic          rst_l,
    input  logic          data_ready,
    input  logic          col_done,
    output logic [IW-1:0] sprite_index,
    output logic          load_init,
    output logic          capture_en,
    output logic          col_start,
    output logic          commit,
    output logic          frame_drop,
    output logic          overrun,
    output logic          busy
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int FW = $clog2(FRAME_CYCLES);

    // Settle counter starts at 0 on the first SETTLE cycle, so the last
    // settle cycle is the one where it reads SETTLE_CYCLES-1.
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(SPRITES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_COLLIDE,
        S_WAIT_FRAME,
        S_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_settle;
    logic [FW-1:0] r_frame;
    logic [IW-1:0] r_idx;
    logic          r_col_start;
    logic          r_frame_drop;
    logic          r_overrun;
    logic          w_boundary;
    logic          w_sweeping;
    logic          w_drop;

    // Frame boundary is the last count of the frame period; only meaningful once started
    assign w_boundary = (r_state != S_IDLE) && (r_frame == FRAME_LAST);
    assign w_sweeping = (r_state == S_SETTLE) || (r_state == S_CAPTURE) || (r_state == S_COLLIDE);
    // A restart request on the boundary cycle suppresses the drop report
    assign w_drop     = w_boundary && w_sweeping && !data_ready;

    // Next-state decode; data_ready overrides everything and forces LOAD
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = S_IDLE;
            S_LOAD:       w_next = S_SETTLE;
            S_SETTLE:     if (r_settle == SETTLE_LAST) w_next = S_CAPTURE;
            S_CAPTURE:    w_next = (r_idx == IDX_LAST) ? S_COLLIDE : S_SETTLE;
            // r_col_start is high exactly on the first COLLIDE cycle, where col_done is ignored
            S_COLLIDE:    if (!r_col_start && col_done) w_next = S_WAIT_FRAME;
            S_WAIT_FRAME: if (w_boundary) w_next = S_COMMIT;
            S_COMMIT:     w_next = S_SETTLE;
            default:      w_next = S_IDLE;
        endcase
        if (data_ready) w_next = S_LOAD;
    end

    // State register
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Settle counter runs only across consecutive SETTLE cycles of one sprite
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            r_settle <= '0;
        end else if ((r_state == S_SETTLE) && (w_next == S_SETTLE)) begin
            r_settle <= r_settle + SW'(1);
        end else begin
            r_settle <= '0;
        end
    end

    // Frame counter reads 0 during LOAD and free-runs with wrap afterwards
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            r_frame <= '0;
        end else if ((w_next == S_LOAD) || (w_next == S_IDLE) || (r_frame == FRAME_LAST)) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + FW'(1);
        end
    end

    // Sprite select: cleared for LOAD/COMMIT, advanced only when leaving CAPTURE for another sprite
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            r_idx <= '0;
        end else if ((w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_COMMIT)) begin
            r_idx <= '0;
        end else if ((r_state == S_CAPTURE) && (w_next == S_SETTLE)) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    // Registered pulse/sticky flags: col_start on COLLIDE entry, drop report and overrun
    always_ff @(posedge clk_162 or negedge rst_l) begin
        if (!rst_l) begin
            r_col_start  <= 1'b0;
            r_frame_drop <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_col_start  <= (w_next == S_COLLIDE) && (r_state != S_COLLIDE);
            r_frame_drop <= w_drop;
            if (w_next == S_LOAD) r_overrun <= 1'b0;
            else if (w_drop)      r_overrun <= 1'b1;
        end
    end

    assign sprite_index = r_idx;
    assign load_init    = (r_state == S_LOAD);
    assign capture_en   = (r_state == S_CAPTURE);
    assign col_start    = r_col_start;
    assign commit       = (r_state == S_COMMIT);
    assign frame_drop   = r_frame_drop;
    assign overrun      = r_overrun;
    assign busy         = w_sweeping;

endmodule

// File: tb/tb_physics_sequencer.sv
// tb/tb_physics_sequencer.sv - self-checking bench for physics_sequencer
module tb_physics_sequencer;

    localparam int N = 3;
    localparam int S = 4;
    localparam int F = 40;
    localparam int L = N * (S + 1);

    logic       clk_162;
    logic       rst_l;
    logic       data_ready;
    logic       col_done;
    logic [1:0] sprite_index;
    logic       load_init, capture_en, col_start, commit, frame_drop, overrun, busy;

    physics_sequencer #(.SPRITES(N), .SETTLE_CYCLES(S), .FRAME_CYCLES(F)) dut (
        .clk_162      (clk_162),
        .rst_l        (rst_l),
        .data_ready   (data_ready),
        .col_done     (col_done),
        .sprite_index (sprite_index),
        .load_init    (load_init),
        .capture_en   (capture_en),
        .col_start    (col_start),
        .commit       (commit),
        .frame_drop   (frame_drop),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk_162 = 1'b0;
    always #5 clk_162 = ~clk_162;

    int tests = 0;
    int fails = 0;

    // bits = {busy, overrun, frame_drop, commit, col_start, capture_en, load_init}
    typedef struct {
        int         scn;
        int         cyc;
        logic [6:0] bits;
        int         idx;
    } vec_t;

    typedef struct {
        int dr2;
        int cd_from;
        int cd_to;
        int len;
    } scn_t;

    vec_t vt[$];
    scn_t sc[6];

    function automatic logic [6:0] outs();
        return {busy, overrun, frame_drop, commit, col_start, capture_en, load_init};
    endfunction

    task automatic check(input string name, input logic [6:0] eb, input int ei);
        tests++;
        if (outs() !== eb || sprite_index !== 2'(ei)) begin
            fails++;
            $display("FAIL %s: got bits=%b idx=%0d, want bits=%b idx=%0d",
                     name, outs(), sprite_index, eb, ei);
        end
    endtask

    task automatic do_reset();
        rst_l      = 1'b0;
        data_ready = 1'b0;
        col_done   = 1'b0;
        repeat (2) @(posedge clk_162);
        @(negedge clk_162);
        rst_l = 1'b1;
    endtask

    // Reference model: times relative to the last LOAD / sweep start
    bit m_active;
    int t_load, base, wait_from, drop_at;
    bit ovr;

    task automatic model_out(input int c, output logic [6:0] eb, output int ei);
        int  d;
        bit  in_wait, cap, cs, bz;
        eb = '0;
        ei = 0;
        if (m_active) begin
            d       = c - base;
            in_wait = (wait_from >= 0) && (c >= wait_from);
            cap = 0; cs = 0; bz = 0;
            if (d == 0)        ei = 0;
            else if (in_wait)  ei = N - 1;
            else if (d <= L) begin
                bz = 1; ei = (d - 1) / (S + 1); cap = (d % (S + 1) == 0);
            end else begin
                bz = 1; ei = N - 1; cs = (d == L + 1);
            end
            eb = {bz, ovr, (c == drop_at), (c == base && c != t_load), cs, cap, (c == t_load)};
        end
    endtask

    task automatic model_step(input int c, input bit dr, input bit cd);
        int d;
        bit in_wait, bnd;
        if (dr) begin
            m_active = 1; t_load = c + 1; base = c + 1;
            wait_from = -1; drop_at = -1; ovr = 0;
        end else if (m_active) begin
            d       = c - base;
            in_wait = (wait_from >= 0) && (c >= wait_from);
            bnd     = ((c - t_load) % F) == (F - 1);
            if (bnd && in_wait) begin
                base = c + 1; wait_from = -1;
            end else if (bnd && d != 0) begin
                drop_at = c + 1; ovr = 1;
            end
            if (!in_wait && d > L + 1 && cd) wait_from = c + 1;
        end
    endtask

    initial begin
        logic [6:0] eb;
        int         ei;
        int         activity;
        int         p;
        bit         dr, cd;

        sc[0] = '{-99, 19, 19, 46};
        sc[1] = '{-99, 45, 45, 81};
        sc[2] = '{12, 999, 999, 29};
        sc[3] = '{39, 19, 19, 42};
        sc[4] = '{-99, 2, 17, 19};
        sc[5] = '{42, 999, 999, 44};

        vt.push_back('{0, 0,  7'b0000001, 0});
        vt.push_back('{0, 5,  7'b1000010, 0});
        vt.push_back('{0, 10, 7'b1000010, 1});
        vt.push_back('{0, 15, 7'b1000010, 2});
        vt.push_back('{0, 16, 7'b1000100, 2});
        vt.push_back('{0, 19, 7'b1000000, 2});
        vt.push_back('{0, 20, 7'b0000000, 2});
        vt.push_back('{0, 39, 7'b0000000, 2});
        vt.push_back('{0, 40, 7'b0001000, 0});
        vt.push_back('{0, 45, 7'b1000010, 0});
        vt.push_back('{1, 39, 7'b1000000, 2});
        vt.push_back('{1, 40, 7'b1110000, 2});
        vt.push_back('{1, 41, 7'b1100000, 2});
        vt.push_back('{1, 46, 7'b0100000, 2});
        vt.push_back('{1, 80, 7'b0101000, 0});
        vt.push_back('{2, 13, 7'b0000001, 0});
        vt.push_back('{2, 15, 7'b1000000, 0});
        vt.push_back('{2, 18, 7'b1000010, 0});
        vt.push_back('{2, 23, 7'b1000010, 1});
        vt.push_back('{2, 28, 7'b1000010, 2});
        vt.push_back('{3, 39, 7'b0000000, 2});
        vt.push_back('{3, 40, 7'b0000001, 0});
        vt.push_back('{3, 41, 7'b1000000, 0});
        vt.push_back('{4, 5,  7'b1000010, 0});
        vt.push_back('{4, 16, 7'b1000100, 2});
        vt.push_back('{4, 17, 7'b1000000, 2});
        vt.push_back('{4, 18, 7'b0000000, 2});
        vt.push_back('{5, 40, 7'b1110000, 2});
        vt.push_back('{5, 42, 7'b1100000, 2});
        vt.push_back('{5, 43, 7'b0000001, 0});

        do_reset();
        #1;
        check("reset_state", 7'b0, 0);

        for (int s = 0; s < 6; s++) begin
            do_reset();
            @(posedge clk_162); #1;
            for (int rel = -1; rel <= sc[s].len; rel++) begin
                for (int v = 0; v < vt.size(); v++)
                    if (vt[v].scn == s && vt[v].cyc == rel)
                        check($sformatf("scn%0d_t+%0d", s, rel), vt[v].bits, vt[v].idx);
                data_ready = (rel == -1) || (rel == sc[s].dr2);
                col_done   = (rel >= sc[s].cd_from) && (rel <= sc[s].cd_to);
                @(posedge clk_162); #1;
            end
        end

        // Asynchronous reset mid-SETTLE, between clock edges
        do_reset();
        @(posedge clk_162); #1;
        data_ready = 1'b1;
        @(posedge clk_162); #1;
        data_ready = 1'b0;
        repeat (7) @(posedge clk_162);
        #3;
        rst_l = 1'b0;
        #1;
        check("async_reset_immediate", 7'b0, 0);
        @(negedge clk_162);
        rst_l = 1'b1;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_162); #1;
            if (outs() != 7'b0 || sprite_index != 2'd0) activity++;
        end
        tests++;
        if (activity != 0) begin
            fails++;
            $display("FAIL post_reset_idle: got %0d active cycles, want 0", activity);
        end
        data_ready = 1'b1;
        @(posedge clk_162); #1;
        data_ready = 1'b0;
        check("post_reset_load", 7'b0000001, 0);

        // Randomized run against the reference model
        do_reset();
        @(posedge clk_162); #1;
        m_active = 0; t_load = 0; base = 0; wait_from = -1; drop_at = -1; ovr = 0;
        p = 10;
        for (int c = 0; c < 4000; c++) begin
            model_out(c, eb, ei);
            check($sformatf("rand_c%0d", c), eb, ei);
            if (c % 200 == 0) p = (c / 200) % 3 == 0 ? 2 : ((c / 200) % 3 == 1 ? 10 : 50);
            dr = ($urandom_range(0, 199) == 0) || (c == 0);
            cd = ($urandom_range(0, 99) < p);
            data_ready = dr;
            col_done   = cd;
            model_step(c, dr, cd);
            @(posedge clk_162); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
